// File: rtl/pong_pkg.sv
// Shared constants, state codes and helpers for the pong game sequencer.
package pong_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned SCORE_W = 4;
    localparam int unsigned DIV_W   = 31;
    localparam int unsigned CNT_W   = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_RALLY = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    localparam logic [SCORE_W-1:0] WIN_SCORE_DEF     = 4'd7;
    localparam logic [CNT_W-1:0]   SERVE_DELAY_DEF   = 8'd8;
    localparam logic [CNT_W-1:0]   POINT_HOLD_DEF    = 8'd16;
    localparam logic [DIV_W-1:0]   DIV_INIT_DEF      = 31'd4000000;
    localparam logic [DIV_W-1:0]   DIV_STEP_DEF      = 31'd250000;
    localparam logic [DIV_W-1:0]   DIV_MIN_DEF       = 31'd1000000;
    localparam logic [SCORE_W-1:0] HITS_PER_STEP_DEF = 4'd4;

    localparam logic SIDE_BAR1 = 1'b0;
    localparam logic SIDE_BAR2 = 1'b1;

    // Saturating decrement; the compare is done one bit wider so floor+step cannot wrap.
    function automatic logic [DIV_W-1:0] div_dec(input logic [DIV_W-1:0] cur,
                                                 input logic [DIV_W-1:0] step,
                                                 input logic [DIV_W-1:0] floor);
        if ({1'b0, cur} >= ({1'b0, floor} + {1'b0, step}))
            return cur - step;
        return floor;
    endfunction

endpackage

// File: rtl/pong_rally_ctrl_if.sv
// Handshake bundle between the pong front end / ball logic and the rally sequencer.
interface pong_rally_ctrl_if;
    import pong_pkg::*;

    logic               start_i;
    logic               ball_tick_i;
    logic               hit_i;
    logic               miss1_i;
    logic               miss2_i;
    logic               ball_run_o;
    logic               ball_load_o;
    logic               serve_side_o;
    logic [DIV_W-1:0]   step_div_o;
    logic [SCORE_W-1:0] score1_o;
    logic [SCORE_W-1:0] score2_o;
    logic               game_over_o;
    logic [STATE_W-1:0] state_o;

    modport master (
        output start_i, ball_tick_i, hit_i, miss1_i, miss2_i,
        input  ball_run_o, ball_load_o, serve_side_o, step_div_o,
               score1_o, score2_o, game_over_o, state_o
    );

    modport slave (
        input  start_i, ball_tick_i, hit_i, miss1_i, miss2_i,
        output ball_run_o, ball_load_o, serve_side_o, step_div_o,
               score1_o, score2_o, game_over_o, state_o
    );

endinterface

// File: rtl/strobe_counter.sv
// Counts strobes up to a runtime target; done_c fires on the target-th strobe, clr_i wins over strobe_i.
module strobe_counter
    import pong_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             strobe_i,
    input  logic [CNT_W-1:0] n_i,
    output logic             done_c
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d  = cnt_q;
        done_c = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (strobe_i) begin
            if (cnt_q + CNT_W'(1) == n_i) begin
                done_c = 1'b1;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/pong_rally_ctrl.sv
// Pong game sequencer: serve/rally/point/game-over flow, scores and ball speed-up.
module pong_rally_ctrl
    import pong_pkg::*;
#(
    parameter logic [SCORE_W-1:0] WIN_SCORE     = WIN_SCORE_DEF,
    parameter logic [CNT_W-1:0]   SERVE_DELAY   = SERVE_DELAY_DEF,
    parameter logic [CNT_W-1:0]   POINT_HOLD    = POINT_HOLD_DEF,
    parameter logic [DIV_W-1:0]   DIV_INIT      = DIV_INIT_DEF,
    parameter logic [DIV_W-1:0]   DIV_STEP      = DIV_STEP_DEF,
    parameter logic [DIV_W-1:0]   DIV_MIN       = DIV_MIN_DEF,
    parameter logic [SCORE_W-1:0] HITS_PER_STEP = HITS_PER_STEP_DEF
) (
    input  logic              clk,
    input  logic              rst,
    pong_rally_ctrl_if.slave  bus
);

    state_e             state_q, state_d;
    logic               entry_q;
    logic               ball_run_q, ball_run_d;
    logic               ball_load_q, ball_load_d;
    logic               side_q, side_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [SCORE_W-1:0] s1_q, s1_d;
    logic [SCORE_W-1:0] s2_q, s2_d;
    logic [SCORE_W-1:0] hits_q, hits_d;
    logic               over_q, over_d;

    logic               tick_done_c;
    logic               cnt_strobe_c;
    logic [CNT_W-1:0]   cnt_target_c;

    // Clearing during the first cycle of a state keeps an entry-cycle tick uncounted.
    assign cnt_strobe_c = bus.ball_tick_i & ((state_q == ST_SERVE) | (state_q == ST_POINT));
    assign cnt_target_c = (state_q == ST_SERVE) ? SERVE_DELAY : POINT_HOLD;

    strobe_counter u_tick_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (entry_q),
        .strobe_i (cnt_strobe_c),
        .n_i      (cnt_target_c),
        .done_c   (tick_done_c)
    );

    always_comb begin
        state_d     = state_q;
        ball_load_d = 1'b0;
        side_d      = side_q;
        div_d       = div_q;
        s1_d        = s1_q;
        s2_d        = s2_q;
        hits_d      = hits_q;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (bus.start_i) begin
                    state_d     = ST_SERVE;
                    s1_d        = '0;
                    s2_d        = '0;
                    side_d      = SIDE_BAR1;
                    div_d       = DIV_INIT;
                    hits_d      = '0;
                    ball_load_d = 1'b1;
                end
            end
            ST_SERVE: begin
                if (tick_done_c) state_d = ST_RALLY;
            end
            ST_RALLY: begin
                if (bus.miss1_i && bus.miss2_i) begin
                    state_d = ST_POINT;
                end else if (bus.miss1_i) begin
                    s2_d    = s2_q + SCORE_W'(1);
                    side_d  = SIDE_BAR1;
                    state_d = ST_POINT;
                end else if (bus.miss2_i) begin
                    s1_d    = s1_q + SCORE_W'(1);
                    side_d  = SIDE_BAR2;
                    state_d = ST_POINT;
                end else if (bus.hit_i) begin
                    if (hits_q + SCORE_W'(1) == HITS_PER_STEP) begin
                        hits_d = '0;
                        div_d  = div_dec(div_q, DIV_STEP, DIV_MIN);
                    end else begin
                        hits_d = hits_q + SCORE_W'(1);
                    end
                end
            end
            ST_POINT: begin
                if (tick_done_c) begin
                    if ((s1_q == WIN_SCORE) || (s2_q == WIN_SCORE)) begin
                        state_d = ST_OVER;
                    end else begin
                        state_d     = ST_SERVE;
                        ball_load_d = 1'b1;
                        div_d       = DIV_INIT;
                        hits_d      = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        ball_run_d = (state_d == ST_RALLY);
        over_d     = (state_d == ST_OVER);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            entry_q     <= 1'b0;
            ball_run_q  <= 1'b0;
            ball_load_q <= 1'b0;
            side_q      <= SIDE_BAR1;
            div_q       <= DIV_INIT;
            s1_q        <= '0;
            s2_q        <= '0;
            hits_q      <= '0;
            over_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            entry_q     <= (state_d != state_q);
            ball_run_q  <= ball_run_d;
            ball_load_q <= ball_load_d;
            side_q      <= side_d;
            div_q       <= div_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            hits_q      <= hits_d;
            over_q      <= over_d;
        end
    end

    assign bus.state_o      = state_q;
    assign bus.ball_run_o   = ball_run_q;
    assign bus.ball_load_o  = ball_load_q;
    assign bus.serve_side_o = side_q;
    assign bus.step_div_o   = div_q;
    assign bus.score1_o     = s1_q;
    assign bus.score2_o     = s2_q;
    assign bus.game_over_o  = over_q;

endmodule
